// File: rtl/flit_operand_injector_pkg.sv
// Shared types for the flit operand injector: FSM state encoding and LFSR taps.
// The LFSR step is only meaningful when the flit word is 44 bits wide (N=22).
package inj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } inj_state_e;

    // Galois taps for x^44 + x^43 + x^18 + x^17 + 1, left-shifting form
    localparam logic [43:0] LFSR_TAPS = 44'h80000060001;

    function automatic logic [43:0] lfsr_step(input logic [43:0] x);
        lfsr_step = {x[42:0], 1'b0} ^ (x[43] ? LFSR_TAPS : 44'h0);
    endfunction

endpackage

// File: rtl/flit_operand_injector_if.sv
// Operand/flit handshake bundle between the injector and the adder under test.
interface flit_operand_injector_if #(
    parameter int N = 22
);
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         op_valid;
    logic         op_ready;
    logic         pkt_start;
    logic         pkt_end;

    modport master (output op_a, op_b, op_valid, pkt_start, pkt_end, input op_ready);
    modport slave  (input op_a, op_b, op_valid, pkt_start, pkt_end, output op_ready);
endinterface

// File: rtl/flit_operand_injector_pattern_gen.sv
// Flit word source: thermometer counter by default, 44-bit Galois LFSR when
// INJ_LFSR_EN is defined. word is registered and only moves on load/advance.
module inj_pattern_gen #(
    parameter int              N         = 22,
    parameter logic [2*N-1:0]  LFSR_SEED = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           advance,
    output logic [2*N-1:0] word
);
    localparam int W = 2 * N;

    if (LFSR_SEED == '0) begin : g_seed_chk
        $error("LFSR_SEED must be nonzero");
    end

    logic [W-1:0] word_q, word_d;

`ifdef INJ_LFSR_EN
    import inj_pkg::*;

    logic [W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        word_d = word_q;
        if (load) begin
            lfsr_d = lfsr_step(LFSR_SEED);
            word_d = lfsr_d;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
            word_d = lfsr_d;
        end
    end

    // word stays 0 out of reset; the LFSR itself holds the seed
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            word_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            word_q <= word_d;
        end
    end
`else
    localparam int GW = $clog2(W + 1);

    logic [GW-1:0] g_q, g_d;

    function automatic logic [W-1:0] therm(input logic [GW-1:0] g);
        logic [W-1:0] t;
        for (int i = 0; i < W; i++) t[i] = (GW'(i) < g);
        return t;
    endfunction

    always_comb begin
        g_d    = g_q;
        word_d = word_q;
        if (load) begin
            g_d = GW'(1);
        end else if (advance) begin
            g_d = (g_q == GW'(W)) ? '0 : g_q + GW'(1);
        end
        if (load || advance) word_d = therm(g_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q    <= '0;
            word_q <= '0;
        end else begin
            g_q    <= g_d;
            word_q <= word_d;
        end
    end
`endif

    assign word = word_q;

endmodule

// File: rtl/flit_operand_injector.sv
// Packetised operand stimulus for adder energy characterisation: NUM_PKTS packets
// of PAYLOAD flits with GAP idle cycles after each. INJ_LFSR_EN selects LFSR words.
module flit_operand_injector #(
    parameter int             N         = 22,
    parameter int             PAYLOAD   = 20,
    parameter int             NUM_PKTS  = 10,
    parameter int             GAP       = 7,
    parameter logic [2*N-1:0] LFSR_SEED = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    flit_operand_injector_if.master           bus,
    output logic [$clog2(PAYLOAD+1)-1:0]      flit_cnt,
    output logic [$clog2(NUM_PKTS+1)-1:0]     pkt_cnt,
    output logic                              busy,
    output logic                              done
);
    import inj_pkg::*;

    localparam int FCW = $clog2(PAYLOAD + 1);
    localparam int PCW = $clog2(NUM_PKTS + 1);
    localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [FCW-1:0] LAST_FLIT = FCW'(PAYLOAD - 1);
    localparam logic [PCW-1:0] PKTS      = PCW'(NUM_PKTS);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP > 0) ? GAP - 1 : 0);

    inj_state_e     state_q, state_d;
    logic [FCW-1:0] flit_cnt_q, flit_cnt_d;
    logic [PCW-1:0] pkt_cnt_q, pkt_cnt_d, pkt_nxt;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
    logic           op_valid_q, op_valid_d;
    logic           pkt_start_q, pkt_start_d;
    logic           pkt_end_q, pkt_end_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load, advance;
    logic [2*N-1:0] word;

    inj_pattern_gen #(.N(N), .LFSR_SEED(LFSR_SEED)) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .word    (word)
    );

    assign pkt_nxt = pkt_cnt_q + PCW'(1);

    // The word only advances when another flit follows, so op_a/op_b keep the
    // last transferred value through the gap and the DONE/IDLE tail.
    always_comb begin
        state_d    = state_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        load       = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_SEND;
                load       = 1'b1;
                flit_cnt_d = '0;
                pkt_cnt_d  = '0;
            end
            ST_SEND: if (bus.op_ready) begin
                if (flit_cnt_q == LAST_FLIT) begin
                    flit_cnt_d = '0;
                    pkt_cnt_d  = pkt_nxt;
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (pkt_nxt < PKTS) begin
                        advance = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    flit_cnt_d = flit_cnt_q + FCW'(1);
                    advance    = 1'b1;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GCW'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    if (pkt_cnt_q < PKTS) begin
                        state_d = ST_SEND;
                        advance = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        op_valid_d  = (state_d == ST_SEND);
        busy_d      = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d      = (state_d == ST_DONE);
        pkt_start_d = op_valid_d && (flit_cnt_d == '0);
        pkt_end_d   = op_valid_d && (flit_cnt_d == LAST_FLIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flit_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            op_valid_q  <= 1'b0;
            pkt_start_q <= 1'b0;
            pkt_end_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flit_cnt_q  <= flit_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            op_valid_q  <= op_valid_d;
            pkt_start_q <= pkt_start_d;
            pkt_end_q   <= pkt_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.op_a      = word[N-1:0];
    assign bus.op_b      = word[2*N-1:N];
    assign bus.op_valid  = op_valid_q;
    assign bus.pkt_start = pkt_start_q;
    assign bus.pkt_end   = pkt_end_q;
    assign flit_cnt      = flit_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
